// File: rtl/uart_frame_loader_if.sv
// Byte-stream in / parameter-RAM write port out for uart_frame_loader.
// The slave modport is the loader's view; master is the UART/RAM side.
interface uart_frame_loader_if #(parameter int ADDR_W = 8);
  logic [7:0]        rx_data;
  logic              rx_done;
  logic              rx_err;
  logic [7:0]        ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_write_n;
  logic              ram_read;
  logic              busy;
  logic              frame_ok;
  logic              frame_err;

  modport master (
    output rx_data, rx_done, rx_err,
    input  ram_data, ram_addr, ram_write_n, ram_read, busy, frame_ok, frame_err
  );

  modport slave (
    input  rx_data, rx_done, rx_err,
    output ram_data, ram_addr, ram_write_n, ram_read, busy, frame_ok, frame_err
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Loads UART frames (header, payload high-to-low address, optional checksum trailer) into the
// channel-parameter RAM. Define UART_FRAME_CKSUM_EN to expect and verify the trailer byte.
module uart_frame_loader #(
  parameter int         FRAME_LEN   = 113,
  parameter logic [7:0] HDR_BYTE    = 8'hAA,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         ADDR_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_frame_loader_if.slave bus
);
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  TMO_MAX  = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, COMMIT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              ph_q, ph_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_n_q, wr_n_d;
  logic              rd_q, rd_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= LAST_IDX;
      sum_q   <= '0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      ph_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      wr_n_q  <= 1'b1;
      rd_q    <= 1'b1;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      ph_q    <= ph_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wr_n_q  <= wr_n_d;
      rd_q    <= rd_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    ph_d    = ph_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wr_n_d  = 1'b1;
    rd_d    = rd_q;
    ok_d    = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.rx_done && !bus.rx_err && bus.rx_data == HDR_BYTE) begin
          state_d = PAYLOAD;
          rd_d    = 1'b0;
          idx_d   = LAST_IDX;
          sum_d   = '0;
        end
      end
      PAYLOAD, CHECK: begin
        // rx_err outranks a same-cycle byte; the byte is dropped with the frame.
        if (bus.rx_err) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (bus.rx_done) begin
          cnt_d = '0;
          if (state_q == PAYLOAD) begin
            sum_d = sum_q + bus.rx_data;
            if (idx_q != '0) begin
              data_d = bus.rx_data;
              addr_d = idx_q;
              wr_n_d = 1'b0;
              idx_d  = idx_q - 1'b1;
            end else begin
              // Start trigger is held until the frame is known good.
              cmd_d = bus.rx_data;
              ph_d  = 1'b0;
`ifdef UART_FRAME_CKSUM_EN
              state_d = CHECK;
`else
              state_d = COMMIT;
`endif
            end
          end else if (bus.rx_data == sum_q) begin
            state_d = COMMIT;
            ph_d    = 1'b0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (cnt_q == TMO_MAX) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        // Two cycles: address-0 write, then unfreeze and report.
        if (!ph_q) begin
          data_d = cmd_q;
          addr_d = '0;
          wr_n_d = 1'b0;
          ph_d   = 1'b1;
        end else begin
          rd_d    = 1'b1;
          ok_d    = 1'b1;
          err_d   = 1'b0;
          ph_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ram_data    = data_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_write_n = wr_n_q;
  assign bus.ram_read    = rd_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_ok    = ok_q;
  assign bus.frame_err   = err_q;
endmodule
